// File: rtl/sar_search_6bits.sv
// MSB-first successive-approximation search against an external comparator.
// Define SAR_EARLY_EXIT_EN to end the search on the first AeqB probe.
module sar_search_6bits #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             AltB,
    input  logic             AeqB,
    input  logic             AgtB,
    output logic [WIDTH-1:0] trial,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             error
);

    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_MSB = KW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [KW-1:0]    k_q, k_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic             error_q, error_d;

    logic             flags_ok;
    logic [WIDTH-1:0] decided;

    assign flags_ok = (AltB ^ AeqB ^ AgtB) && !(AltB && AeqB && AgtB);

    // Bit k survives unless the target is below the trial.
    always_comb begin
        decided = trial_q;
        if (AltB) begin
            decided[k_q] = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        trial_d  = trial_q;
        result_d = result_q;
        k_d      = k_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        found_d  = found_q;
        error_d  = error_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d            = S_PROBE;
                    trial_d            = '0;
                    trial_d[WIDTH-1]   = 1'b1;
                    k_d                = K_MSB;
                    found_d            = 1'b0;
                    error_d            = 1'b0;
                    busy_d             = 1'b1;
                end
            end

            S_PROBE: begin
                if (!flags_ok) begin
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    error_d  = 1'b1;
                    found_d  = 1'b0;
                    result_d = '0;
`ifdef SAR_EARLY_EXIT_EN
                end else if (AeqB) begin
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    found_d  = 1'b1;
                    result_d = trial_q;
`endif
                end else begin
                    if (AeqB) begin
                        found_d = 1'b1;
                    end
                    if (k_q != '0) begin
                        trial_d                 = decided;
                        trial_d[k_q - 1'b1]     = 1'b1;
                        k_d                     = k_q - 1'b1;
                    end else begin
                        state_d  = S_DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        result_d = decided;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            trial_q  <= '0;
            result_q <= '0;
            k_q      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            found_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            k_q      <= k_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            found_q  <= found_d;
            error_q  <= error_d;
        end
    end

    assign trial  = trial_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign found  = found_q;
    assign error  = error_q;

endmodule

// File: tb/tb_sar_search_6bits.sv
// Scoreboard bench for sar_search_6bits with a behavioural comparator model.
module tb_sar_search_6bits;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         AltB, AeqB, AgtB;
    logic [W-1:0] trial;
    logic         busy, done;
    logic [W-1:0] result;
    logic         found, error;

    logic [W-1:0] tgt;
    logic         bad;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         fnd;
        logic         err;
        int           at;
    } exp_t;

    exp_t sb[$];

    sar_search_6bits dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .AltB   (AltB),
        .AeqB   (AeqB),
        .AgtB   (AgtB),
        .trial  (trial),
        .busy   (busy),
        .done   (done),
        .result (result),
        .found  (found),
        .error  (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Comparator: A = target, B = trial; bad forces AltB and AgtB together.
    assign AltB = bad ? 1'b1 : (tgt < trial);
    assign AgtB = bad ? 1'b1 : (tgt > trial);
    assign AeqB = bad ? 1'b0 : (tgt == trial);

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Trial at probe j: target bits above position W-j, plus bit W-j set.
    function automatic int exp_trial(input int t, input int j);
        int p;
        int step;
        p    = W - j;
        step = 1 << (p + 1);
        return (t / step) * step + (1 << p);
    endfunction

    function automatic int n_probes(input int t);
`ifdef SAR_EARLY_EXIT_EN
        if (t != 0) begin
            for (int b = 0; b < W; b++) begin
                if (((t >> b) & 1) == 1) return W - b;
            end
        end
`endif
        return W;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", int'(result), int'(e.res));
                chk("found", int'(found), int'(e.fnd));
                chk("error", int'(error), int'(e.err));
                chk("done_cycle", cyc, e.at);
            end
        end
    end

    // Called just after a clock edge; returns inside the done cycle.
    task automatic run(input int t, input int fault_at, input bit poke);
        int   e0;
        int   np;
        exp_t x;
        tgt   = W'(t);
        bad   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e0    = cyc;
        np    = (fault_at > 0) ? fault_at : n_probes(t);
        x.res = (fault_at > 0) ? '0 : W'(t);
        x.fnd = (fault_at == 0) && (t != 0);
        x.err = (fault_at > 0);
        x.at  = e0 + np;
        sb.push_back(x);
        for (int j = 1; j <= np; j++) begin
            if (j == fault_at) bad = 1'b1;
            if (poke && j == 2) start = 1'b1;
            if (j == 3) start = 1'b0;
            @(negedge clk);
            chk("trial", int'(trial), exp_trial(t, j));
            chk("busy", int'(busy), 1);
            if (j == 1) chk("error_cleared", int'(error), 0);
            @(posedge clk);
            #1;
            bad   = 1'b0;
            start = 1'b0;
        end
    endtask

    initial begin
        int t;
        int f;
        int np;
        bit pk;
        rst   = 1'b1;
        start = 1'b1;
        tgt   = '0;
        bad   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_trial", int'(trial), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_found", int'(found), 0);
        chk("rst_error", int'(error), 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run(37, 0, 1'b0);
        run(32, 0, 1'b0);
        run(0, 0, 1'b0);
        run(63, 0, 1'b0);
        run(37, 3, 1'b0);
        run(37, 0, 1'b1);
        repeat (2) @(posedge clk);
        #1;

        // Reset during the second probe cycle.
        tgt   = 6'd45;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_trial", int'(trial), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_result", int'(result), 0);
        chk("mid_rst_found", int'(found), 0);
        chk("mid_rst_error", int'(error), 0);
        repeat (W + 2) @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            t  = $urandom_range(0, 63);
            np = n_probes(t);
            f  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, np) : 0;
            pk = (f == 0) && (np >= 3) && ($urandom_range(0, 2) == 0);
            run(t, f, pk);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
